mem_seq_ctrl: RTL and testbench

Request sequencer sitting directly upstream of the 16x32 half-duplex RAM. It accepts read/write requests over a valid/ready handshake, buffers them in a small in-order queue, and drives the RAM's single shared port (`r_w`, `addr`, `d_in`). It captures the RAM's registered `d_out` and returns read data over a valid/ready response channel. Writes produce no response.

---
 rtl/mem_seq_pkg.sv | 23 ++
 rtl/mem_seq_fifo.sv | 74 +++++++
 rtl/mem_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_seq_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types for the RAM request sequencer: default widths, FSM state
// encoding and the queued request record.
package mem_seq_pkg;

    localparam int MEM_DATA_W = 16;
    localparam int MEM_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDW,
        ST_RSP,
        ST_CLR
    } seq_state_t;

    typedef struct packed {
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_seq_fifo.sv
// In-order request queue for mem_seq_ctrl. Full and empty are registered
// flags derived from the next-state occupancy count.
module mem_seq_fifo
    import mem_seq_pkg::*;
#(
    parameter type T     = mem_req_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic           r_full;
    logic           r_empty;

    logic           w_push;
    logic           w_pop;
    logic [PW:0]    w_count_nxt;

    assign w_push  = i_push && !r_full;
    assign w_pop   = i_pop && !r_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is not reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (PW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Request sequencer in front of the single-port half-duplex RAM.
// Optional bulk clear of the RAM is enabled with MEM_SEQ_CLEAR_EN.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              ram_r_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d_in,
    input  logic [DATA_W-1:0] ram_d_out
`ifdef MEM_SEQ_CLEAR_EN
    ,
    input  logic              clr_start,
    output logic              clr_busy
`endif
);

    // state   | meaning
    // IDLE    | waiting; pops the queue head when one is present
    // WR      | RAM write in progress; may pop the next request
    // RD      | RAM samples the read address
    // RDW     | RAM d_out valid; captured into the response regs
    // RSP     | response held until rsp_ready
    // CLR     | writing zero to every RAM location (clear build only)

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t              w_push_data;
    req_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    seq_state_t        r_state;
    logic              r_ram_r_w;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_d_in;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [ADDR_W-1:0] r_rsp_addr;

`ifdef MEM_SEQ_CLEAR_EN
    logic              r_clr_busy;
    logic [ADDR_W-1:0] r_clr_cnt;

    assign clr_busy  = r_clr_busy;
    assign req_ready = !rst && !w_full && !r_clr_busy;
`else
    assign req_ready = !rst && !w_full;
`endif

    assign w_push_data = {req_write, req_addr, req_wdata};
    assign w_push      = req_valid && req_ready;
    assign w_pop       = ((r_state == ST_IDLE) || (r_state == ST_WR)) && !w_empty;

    assign ram_r_w   = r_ram_r_w;
    assign ram_addr  = r_ram_addr;
    assign ram_d_in  = r_ram_d_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_addr  = r_rsp_addr;

    mem_seq_fifo #(
        .T     (req_t),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ram_r_w   <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_d_in  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_addr  <= '0;
`ifdef MEM_SEQ_CLEAR_EN
            r_clr_busy  <= 1'b0;
            r_clr_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_WR: begin
                    if (!w_empty) begin
                        r_ram_addr <= w_head.addr;
                        if (w_head.write) begin
                            r_ram_d_in <= w_head.wdata;
                            r_ram_r_w  <= 1'b1;
                            r_state    <= ST_WR;
                        end else begin
                            r_ram_r_w  <= 1'b0;
                            r_state    <= ST_RD;
                        end
                    end
`ifdef MEM_SEQ_CLEAR_EN
                    else if ((r_state == ST_IDLE) && clr_start) begin
                        r_ram_addr <= '0;
                        r_ram_d_in <= '0;
                        r_ram_r_w  <= 1'b1;
                        r_clr_busy <= 1'b1;
                        r_clr_cnt  <= '1;
                        r_state    <= ST_CLR;
                    end
`endif
                    else begin
                        r_ram_r_w <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    r_state <= ST_RDW;
                end
                ST_RDW: begin
                    r_rsp_rdata <= ram_d_out;
                    r_rsp_addr  <= r_ram_addr;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RSP;
                end
                // Returning through IDLE keeps the pop off the handshake edge.
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
`ifdef MEM_SEQ_CLEAR_EN
                ST_CLR: begin
                    if (r_clr_cnt == '0) begin
                        r_ram_r_w  <= 1'b0;
                        r_clr_busy <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_clr_cnt  <= r_clr_cnt - 1'b1;
                        r_ram_addr <= r_ram_addr + 1'b1;
                    end
                end
`endif
                default: begin
                    r_ram_r_w <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: behavioural RAM, in-order scoreboard with a shadow
// memory, directed timing checks and a randomized traffic phase.
module tb_mem_seq_ctrl;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] rsp_addr;
    logic          ram_r_w;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d_in;
    logic [DW-1:0] ram_d_out = '0;
`ifdef MEM_SEQ_CLEAR_EN
    logic          clr_start = 1'b0;
    logic          clr_busy;
`endif

    always #5 clk = ~clk;

    mem_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr),
        .ram_r_w   (ram_r_w),
        .ram_addr  (ram_addr),
        .ram_d_in  (ram_d_in),
        .ram_d_out (ram_d_out)
`ifdef MEM_SEQ_CLEAR_EN
        ,
        .clr_start (clr_start),
        .clr_busy  (clr_busy)
`endif
    );

    // Half-duplex RAM with registered read data.
    logic [DW-1:0] ram_mem [32];
    always @(posedge clk) begin
        if (ram_r_w) ram_mem[ram_addr] <= ram_d_in;
        else         ram_d_out <= ram_mem[ram_addr];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          exp_wr[$];
    ent_t          exp_rd[$];
    logic [DW-1:0] shadow [32];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            hold_prev = 1'b0;
    logic [AW+DW-1:0] hold_val;
    ent_t          e;

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = '0;
            shadow[i]  = '0;
        end
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name, int act, int exp);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Per-cycle compare against the in-order model.
    always @(negedge clk) begin
        if (rst) begin
            check("req_ready_in_rst", req_ready, 0);
            exp_wr.delete();
            exp_rd.delete();
            hold_prev = 1'b0;
        end else begin
            if (ram_r_w) begin
`ifdef MEM_SEQ_CLEAR_EN
                if (clr_busy) begin
                    check("clr_wdata", ram_d_in, 0);
                    shadow[ram_addr] = '0;
                end else
`endif
                if (exp_wr.size() == 0) begin
                    fail_now("spurious_ram_write_pending", 0, 1);
                end else begin
                    e = exp_wr.pop_front();
                    check("ram_addr", ram_addr, e.a);
                    check("ram_d_in", ram_d_in, e.d);
                end
            end
            if (hold_prev) begin
                check("rsp_hold_valid", rsp_valid, 1);
                check("rsp_hold_data", {rsp_addr, rsp_rdata}, hold_val);
            end
            if (rsp_valid) begin
                if (rsp_ready) begin
                    hold_prev = 1'b0;
                    if (exp_rd.size() == 0) begin
                        fail_now("unexpected_rsp_pending", 0, 1);
                    end else begin
                        e = exp_rd.pop_front();
                        check("rsp_addr", rsp_addr, e.a);
                        check("rsp_rdata", rsp_rdata, e.d);
                    end
                end else begin
                    hold_prev = 1'b1;
                    hold_val  = {rsp_addr, rsp_rdata};
                end
            end else begin
                hold_prev = 1'b0;
            end
            if (req_valid && req_ready) begin
                if (req_write) begin
                    shadow[req_addr] = req_wdata;
                    exp_wr.push_back({req_addr, req_wdata});
                end else begin
                    exp_rd.push_back({req_addr, shadow[req_addr]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) fail_now("send_timeout", n, 0);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_rd.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) fail_now("drain_timeout", exp_wr.size() + exp_rd.size(), 0);
        tick();
        tick();
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
        send(1'b0, a, '0);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (lat >= 50) fail_now("rsp_timeout", lat, 3);
        d = rsp_rdata;
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [5:0]    pat;
        int            lat;
        int            acc;
        int            any;
        bit            will;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_ram_r_w", ram_r_w, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_d_in", ram_d_in, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", req_ready, 1);
        tick();

        // Write then read addr 3, latency 3 edges from acceptance
        rsp_ready = 1'b1;
        send(1'b1, 5'd3, 16'hA5A5);
        wait_idle();
        send(1'b0, 5'd3, '0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("rd_latency", lat, 3);
        check("rd3_data", rsp_rdata, 16'hA5A5);
        check("rd3_addr", rsp_addr, 3);
        wait_idle();

        // Four back-to-back writes, r_w high on four consecutive cycles
        pat = '0;
        req_valid = 1'b1;
        req_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr  = AW'(i);
            req_wdata = DW'(i + 1);
            tick();
            pat = {pat[4:0], ram_r_w};
        end
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            pat = {pat[4:0], ram_r_w};
        end
        check("wr_burst_pattern", pat, 6'b011110);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            do_read(AW'(i), d, lat);
            check("burst_readback", d, i + 1);
        end

        // Back-pressure: one read in flight plus QDEPTH queued
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = '0;
        for (int k = 0; k < 10; k++) begin
            will = req_ready;
            tick();
            if (will) begin
                acc++;
                req_addr = AW'(acc);
            end
        end
        check("full_accept_count", acc, QD + 1);
        check("full_req_ready", req_ready, 0);
        check("full_rsp_valid", rsp_valid, 1);
        check("full_first_rsp_addr", rsp_addr, 0);
        check("full_first_rsp_data", rsp_rdata, 16'h0001);
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        check("full_hold_addr", rsp_addr, 0);
        rsp_ready = 1'b1;
        wait_idle();

        // Reset while a response is held
        rsp_ready = 1'b0;
        send(1'b0, 5'd2, '0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("pre_rst_rsp_valid", rsp_valid, 1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_req_ready", req_ready, 0);
        tick();
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_ram_addr", ram_addr, 0);
        rst = 1'b0;
        #1;
        check("after_rst_req_ready", req_ready, 1);
        rsp_ready = 1'b1;
        any = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid || ram_r_w) any++;
        end
        check("after_rst_quiet", any, 0);

        // Write 31 then read 31 on the next cycle
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 5'd31;
        req_wdata = 16'hFFFF;
        tick();
        req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        check("wr31_r_w", ram_r_w, 1);
        check("wr31_addr", ram_addr, 31);
        tick();
        check("rd31_after_wr_r_w", ram_r_w, 0);
        check("rd31_after_wr_addr", ram_addr, 31);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("rd31_latency_tail", lat, 2);
        check("rd31_data", rsp_rdata, 16'hFFFF);
        wait_idle();

`ifdef MEM_SEQ_CLEAR_EN
        for (int i = 0; i < 32; i++) begin
            send(1'b1, AW'(i), DW'(16'h1000 + i));
        end
        wait_idle();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        lat = 0;
        any = 0;
        while (clr_busy && lat < 100) begin
            if (req_ready) any++;
            lat++;
            tick();
        end
        check("clr_busy_cycles", lat, 32);
        check("clr_req_ready_low", any, 0);
        do_read(5'd17, d, lat);
        check("clr_rd17", d, 0);
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 31));
            req_wdata = DW'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        check("final_wr_queue_empty", exp_wr.size(), 0);
        check("final_rd_queue_empty", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
